data_mem_arbiter: RTL and testbench

//  Shares the single-port data RAM between the CPU MEM stage and the parallel/display read port.

---
 rtl/arb_pkg.sv | 6 +
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/data_mem_arbiter.sv | 115 +++++++++++
 tb/tb_data_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the data RAM arbiter
package arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_CPU_RD, ARB_DISP_RD} arb_state_t;
  typedef enum logic {GNT_CPU, GNT_DISP} arb_gnt_t;
  localparam int unsigned STARVE_W = 8;
endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of display cycles denied the RAM
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX_V) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign at_max = (cnt == MAX_V);
endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the data RAM between the MEM stage and the display reader
// ARB_PERF_EN adds perf_stall_cnt / perf_disp_cnt.
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int AW         = 24,
  parameter int DW         = 24,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_q
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_disp_cnt
`endif
);
  arb_state_t state, state_nxt;
  arb_gnt_t   gnt;
  logic       at_max, disp_pend, disp_gnt;

  // A display request already being read or just answered must not be granted again.
  assign disp_pend = disp_req && (state != ARB_DISP_RD) && !disp_rvalid;

  always_comb begin
    state_nxt  = state;
    gnt        = GNT_CPU;
    disp_gnt   = 1'b0;
    cpu_stall  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    if (rst) begin
      unique case (state)
        ARB_IDLE: begin
          if (disp_pend && (at_max || !cpu_req)) gnt = GNT_DISP;
          if (gnt == GNT_DISP) begin
            disp_gnt  = 1'b1;
            ram_addr  = disp_addr;
            cpu_stall = cpu_req;
            state_nxt = ARB_DISP_RD;
          end else if (cpu_req) begin
            ram_addr = cpu_addr;
            if (cpu_we) begin
              ram_we    = 1'b1;
              ram_wdata = cpu_wdata;
            end else begin
              cpu_stall = 1'b1;
              state_nxt = ARB_CPU_RD;
            end
          end
        end
        ARB_CPU_RD: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = ram_q;
          state_nxt  = ARB_IDLE;
        end
        ARB_DISP_RD: begin
          cpu_stall = cpu_req;
          state_nxt = ARB_IDLE;
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      disp_rvalid <= (state == ARB_DISP_RD);
      if (state == ARB_DISP_RD) disp_rdata <= ram_q;
    end
  end

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (disp_pend && !disp_gnt),
    .clr    (disp_gnt || !disp_req),
    .at_max (at_max)
  );

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_disp_cnt  <= '0;
    end else begin
      if (cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (disp_gnt)  perf_disp_cnt  <= perf_disp_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
  localparam int AW = 24;
  localparam int DW = 24;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q = '0;
`ifdef ARB_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_disp_cnt;
`endif

  data_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
`ifdef ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_disp_cnt(perf_disp_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // RAM macro: registered read, read-before-write
  logic [DW-1:0] ram_arr [0:255];
  logic [DW-1:0] shadow  [0:255];
  initial for (int i = 0; i < 256; i++) begin ram_arr[i] = '0; shadow[i] = '0; end
  always @(posedge clk) begin
    ram_q <= ram_arr[ram_addr[7:0]];
    if (ram_we) ram_arr[ram_addr[7:0]] <= ram_wdata;
  end

  // Reference model: 0 = RAM free, 1 = CPU read data returning, 2 = display read data returning
  int            m_phase = 0, m_starve = 0, nphase;
  logic [7:0]    m_rd_addr = '0, m_disp_addr = '0;
  logic          e_dv = 1'b0;
  logic [DW-1:0] e_drd = '0;
  logic [31:0]   m_stall_cnt = '0, m_disp_cnt = '0;
  logic          dpend, dwin, e_stall, e_rv, e_we;
  logic [DW-1:0] e_rd, e_wd;
  logic [AW-1:0] e_addr;

  always @(negedge clk) begin
    if (!rst) begin
      m_phase = 0; m_starve = 0; e_dv = 1'b0; e_drd = '0;
      m_stall_cnt = '0; m_disp_cnt = '0;
    end else begin
      dpend = disp_req && m_phase != 2 && !e_dv;
      dwin  = m_phase == 0 && dpend && (m_starve == SMAX || !cpu_req);
      e_stall = 1'b0; e_rv = 1'b0; e_rd = '0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (m_phase == 0) begin
        if (dwin) begin
          e_addr = disp_addr; e_stall = cpu_req;
        end else if (cpu_req) begin
          e_addr = cpu_addr;
          if (cpu_we) begin e_we = 1'b1; e_wd = cpu_wdata; end
          else e_stall = 1'b1;
        end
      end else if (m_phase == 1) begin
        e_rv = 1'b1; e_rd = shadow[m_rd_addr];
      end else begin
        e_stall = cpu_req;
      end
      chk("cpu_stall", 64'(cpu_stall), 64'(e_stall));
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_rv));
      if (e_rv) chk("cpu_rdata", 64'(cpu_rdata), 64'(e_rd));
      chk("ram_we", 64'(ram_we), 64'(e_we));
      chk("ram_addr", 64'(ram_addr), 64'(e_addr));
      chk("ram_wdata", 64'(ram_wdata), 64'(e_wd));
      chk("disp_rvalid", 64'(disp_rvalid), 64'(e_dv));
      chk("disp_rdata", 64'(disp_rdata), 64'(e_drd));
`ifdef ARB_PERF_EN
      chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
      chk("perf_disp_cnt", 64'(perf_disp_cnt), 64'(m_disp_cnt));
`endif
      nphase = 0;
      if (dwin) begin nphase = 2; m_disp_addr = disp_addr[7:0]; end
      else if (m_phase == 0 && cpu_req && !cpu_we) begin nphase = 1; m_rd_addr = cpu_addr[7:0]; end
      if (e_we) shadow[cpu_addr[7:0]] = cpu_wdata;
      e_dv = (m_phase == 2);
      if (m_phase == 2) e_drd = shadow[m_disp_addr];
      if (dwin || !disp_req) m_starve = 0;
      else if (dpend && m_starve < SMAX) m_starve++;
      m_stall_cnt += 32'(e_stall);
      m_disp_cnt  += 32'(dwin);
      m_phase = nphase;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Continuous CPU writes with the display waiting; reports grant cycle and stall count.
  task automatic starve_round(output int first, output int stalls, output bit seen,
                              output logic [31:0] dstall, output logic [31:0] ddisp);
    logic st, dv;
    logic [31:0] s0 = '0, d0 = '0;
    first = 0; stalls = 0; seen = 1'b0; dstall = '0; ddisp = '0;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = AW'(8'h40 + 8'($urandom_range(0, 15))); cpu_wdata = DW'($urandom);
    disp_req = 1'b1; disp_addr = AW'(8'h20);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      st = cpu_stall; dv = disp_rvalid;
`ifdef ARB_PERF_EN
      if (c == 1) begin s0 = perf_stall_cnt; d0 = perf_disp_cnt; end
      if (dv) begin dstall = perf_stall_cnt - s0; ddisp = perf_disp_cnt - d0; end
`else
      if (c == 1) begin s0 = '0; d0 = '0; end
`endif
      if (st) begin stalls++; if (first == 0) first = c; end
      tick();
      if (!st) begin cpu_addr = AW'(8'h40 + 8'($urandom_range(0, 15))); cpu_wdata = DW'($urandom); end
      if (dv) begin disp_req = 1'b0; seen = 1'b1; break; end
    end
  endtask

  int first, stalls;
  bit seen;
  logic [31:0] dstall, ddisp;
  logic st, dv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rst disp_rdata", 64'(disp_rdata), 64'd0);
    chk("rst ram_addr", 64'(ram_addr), 64'd0);
    tick(); rst = 1'b1;
    tick();

    // CPU write then read-back of 0x10
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(24'h10); cpu_wdata = DW'(24'hABCDEF);
    @(negedge clk);
    chk("wr ram_we", 64'(ram_we), 64'd1);
    chk("wr cpu_stall", 64'(cpu_stall), 64'd0);
    tick(); cpu_we = 1'b0;
    @(negedge clk);
    chk("rd stall", 64'(cpu_stall), 64'd1);
    tick();
    @(negedge clk);
    chk("rd rvalid", 64'(cpu_rvalid), 64'd1);
    chk("rd rdata", 64'(cpu_rdata), 64'hABCDEF);
    tick();

    // Display read of 0x20
    cpu_we = 1'b1; cpu_addr = AW'(24'h20); cpu_wdata = DW'(24'h123456);
    tick(); cpu_req = 1'b0;
    disp_req = 1'b1; disp_addr = AW'(24'h20);
    @(negedge clk); chk("disp c0 rvalid", 64'(disp_rvalid), 64'd0);
    tick(); @(negedge clk); chk("disp c1 rvalid", 64'(disp_rvalid), 64'd0);
    tick(); @(negedge clk);
    chk("disp c2 rvalid", 64'(disp_rvalid), 64'd1);
    chk("disp c2 rdata", 64'(disp_rdata), 64'h123456);
    tick(); disp_req = 1'b0;
    @(negedge clk);
    chk("disp held rvalid", 64'(disp_rvalid), 64'd0);
    chk("disp held rdata", 64'(disp_rdata), 64'h123456);
    tick();

    // Reset in the middle of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(24'h10);
    tick(); #2 rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    chk("midrst rvalid", 64'(cpu_rvalid), 64'd0);
    chk("midrst ram_we", 64'(ram_we), 64'd0);
    chk("midrst stall", 64'(cpu_stall), 64'd0);
    chk("midrst disp_rdata", 64'(disp_rdata), 64'd0);
    tick(); rst = 1'b1;
    tick();

    // Starvation under back-to-back writes
    starve_round(first, stalls, seen, dstall, ddisp);
    chk("starve seen", 64'(seen), 64'd1);
    chk("starve grant cycle", 64'(first), 64'd9);
    chk("starve stalls", 64'(stalls), 64'd2);
`ifdef ARB_PERF_EN
    chk("perf stall delta", 64'(dstall), 64'd2);
    chk("perf disp delta", 64'(ddisp), 64'd1);
`endif
    // A dropped display request forfeits its accumulated priority
    disp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); cpu_addr = AW'(8'h40 + 8'(i)); cpu_wdata = DW'($urandom);
    end
    disp_req = 1'b0;
    tick();
    starve_round(first, stalls, seen, dstall, ddisp);
    chk("drop seen", 64'(seen), 64'd1);
    chk("drop grant cycle", 64'(first), 64'd9);
    cpu_req = 1'b0;
    tick(); tick();

    // Simultaneous CPU read and display request
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(24'h10);
    disp_req = 1'b1; disp_addr = AW'(24'h20);
    @(negedge clk);
    chk("sim c1 stall", 64'(cpu_stall), 64'd1);
    chk("sim c1 addr", 64'(ram_addr), 64'h10);
    tick(); @(negedge clk);
    chk("sim c2 rvalid", 64'(cpu_rvalid), 64'd1);
    chk("sim c2 rdata", 64'(cpu_rdata), 64'hABCDEF);
    tick(); cpu_req = 1'b0;
    @(negedge clk); chk("sim c3 addr", 64'(ram_addr), 64'h20);
    tick(); tick(); @(negedge clk);
    chk("sim c5 rvalid", 64'(disp_rvalid), 64'd1);
    chk("sim c5 rdata", 64'(disp_rdata), 64'h123456);
    tick(); disp_req = 1'b0;
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); st = cpu_stall; dv = disp_rvalid;
      tick();
      if (cpu_req && !st) cpu_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 99) < 60) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 63)); cpu_wdata = DW'($urandom);
      end
      if (disp_req && dv) disp_req = 1'b0;
      else if (!disp_req && $urandom_range(0, 99) < 25) begin
        disp_req = 1'b1; disp_addr = AW'($urandom_range(0, 63));
      end
    end
    cpu_req = 1'b0; disp_req = 1'b0;
    tick(); tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
